// File: rtl/light_chaser_multi.sv
// N-LED pattern generator with selectable chase-left, chase-right, bounce and fill/drain patterns.
// A programmable prescaler sets the step rate; dir and wrap let outside logic follow the pattern.
module light_chaser_multi #(
  parameter int N     = 5,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] step_div,
  output logic [N-1:0]     l,
  output logic             dir,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  localparam logic [N-1:0] LSB_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MSB_ONE  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ZERO     = {N{1'b0}};

  logic [N-1:0]     l_q, l_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;

  logic             step;
  logic [N-1:0]     start_l;
  logic             start_dir;
  logic             onehot, therm, bounce_ok, fill_ok;
  logic [N-1:0]     rot_l, rot_r, shl, shr, fill_up;

  assign step = enable && (cnt_q >= step_div);

  // Start state of the requested mode; on a same-mode reload mode equals mode_q anyway.
  always_comb begin
    start_l   = LSB_ONE;
    start_dir = 1'b1;
    case (mode_e'(mode))
      MODE_RIGHT: begin
        start_l   = MSB_ONE;
        start_dir = 1'b0;
      end
      MODE_FILL:  start_l = ZERO;
      default:    ;
    endcase
  end

  assign onehot    = (l_q != ZERO) && ((l_q & (l_q - LSB_ONE)) == ZERO);
  assign therm     = ((l_q & (l_q + LSB_ONE)) == ZERO);
  assign bounce_ok = onehot && !(dir_q && l_q[N-1]) && !(!dir_q && l_q[0]);
  assign fill_ok   = therm && !(dir_q && (l_q == ALL_ONES)) && !(!dir_q && (l_q == ZERO));
  assign rot_l     = {l_q[N-2:0], l_q[N-1]};
  assign rot_r     = {l_q[0], l_q[N-1:1]};
  assign shl       = l_q << 1;
  assign shr       = l_q >> 1;
  assign fill_up   = {l_q[N-2:0], 1'b1};

  always_comb begin
    l_d    = l_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (enable) begin
      cnt_d = step ? '0 : cnt_q + DIV_W'(1);
    end
    if (step) begin
      if (mode_e'(mode) != mode_q) begin
        mode_d = mode_e'(mode);
        l_d    = start_l;
        dir_d  = start_dir;
      end else begin
        // Any pattern that the current mode could never reach falls back to the start state.
        l_d   = start_l;
        dir_d = start_dir;
        case (mode_q)
          MODE_LEFT: if (onehot) begin
            l_d    = rot_l;
            dir_d  = 1'b1;
            wrap_d = (l_q == MSB_ONE);
          end
          MODE_RIGHT: if (onehot) begin
            l_d    = rot_r;
            dir_d  = 1'b0;
            wrap_d = (l_q == LSB_ONE);
          end
          MODE_BOUNCE: if (bounce_ok) begin
            if (dir_q) begin
              l_d   = shl;
              dir_d = !shl[N-1];
            end else begin
              l_d    = shr;
              dir_d  = (shr == LSB_ONE);
              wrap_d = (shr == LSB_ONE);
            end
          end
          MODE_FILL: if (fill_ok) begin
            if (dir_q) begin
              l_d   = fill_up;
              dir_d = (fill_up != ALL_ONES);
            end else begin
              l_d    = shr;
              dir_d  = (shr == ZERO);
              wrap_d = (shr == ZERO);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_q    <= LSB_ONE;
      dir_q  <= 1'b1;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_LEFT;
    end else begin
      l_q    <= l_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  assign l    = l_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;

endmodule
